// File: rtl/dmem_access_controller.sv
// dmem_access_controller
//   Sequences the memory stage's data-memory access. A load or store seen in
//   the memory stage is registered, issued on a valid/ready request port, and
//   the pipeline is stalled until the response arrives. Load data is captured
//   and presented with its destination register for one writeback cycle.
//
//   Optional build macro: MEM_TIMEOUT_EN
//     When defined, an access that stays in REQ/WAIT for TIMEOUT_CYCLES
//     cycles is forced to complete, with zero data and a sticky mem_error.
//     When undefined, the controller waits indefinitely and mem_error is 0.
//
// Ports
//   clock, reset              clock (posedge) and synchronous active-high reset
//   memRead_memory            load in memory stage
//   memWrite_memory           store in memory stage
//   regWrite_memory           instruction writes rd
//   rd_memory                 destination register
//   addr_memory, wdata_memory effective address and store data
//   stall_pipeline            freeze IF..MEM stages
//   mem_req_*                 request channel (valid/ready, write, addr, wdata)
//   mem_rsp_valid, _data      response/ack channel
//   memory_data_memory        captured load data
//   load_done, load_we        one-cycle completion pulse and qualified write-enable
//   rd_load                   destination of the completed load
//   mem_error                 sticky timeout flag
module dmem_access_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  memRead_memory,
    input  logic                  memWrite_memory,
    input  logic                  regWrite_memory,
    input  logic [4:0]            rd_memory,
    input  logic [ADDR_WIDTH-1:0] addr_memory,
    input  logic [DATA_WIDTH-1:0] wdata_memory,
    output logic                  stall_pipeline,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    output logic [DATA_WIDTH-1:0] memory_data_memory,
    output logic                  load_done,
    output logic                  load_we,
    output logic [4:0]            rd_load,
    output logic                  mem_error
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

    state_t     state, state_next;
    logic       accept;        // op registered this cycle (IDLE -> REQ)
    logic       rsp_take;      // response consumed this cycle (WAIT -> DONE)
    logic       timeout_fire;  // access abandoned this cycle (REQ/WAIT -> DONE)
    logic       timeout_hit;
    logic [4:0] rd_q;
    logic       regwrite_q;

    // The request is valid for exactly the REQ state; the operands behind it
    // are registered at accept and held untouched until the next accept.
    assign mem_req_valid = (state == ST_REQ);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        stall_pipeline = 1'b0;
        accept         = 1'b0;
        rsp_take       = 1'b0;
        timeout_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (memRead_memory || memWrite_memory) begin
                    stall_pipeline = 1'b1;
                    accept         = 1'b1;
                    state_next     = ST_REQ;
                end
            end
            ST_REQ: begin
                stall_pipeline = 1'b1;
                if (mem_req_ready) begin
                    state_next = ST_WAIT;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_next   = ST_DONE;
                end
            end
            ST_WAIT: begin
                stall_pipeline = 1'b1;
                if (mem_rsp_valid) begin
                    rsp_take   = 1'b1;
                    state_next = ST_DONE;
                end else if (timeout_hit) begin
                    timeout_fire = 1'b1;
                    state_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                // Always return to IDLE so the advancing instruction is never
                // issued a second time.
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request operands, captured load data and the completion pulse. The
    // pulse outputs are registered on the transition into DONE so they are
    // high for exactly the DONE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req_write      <= 1'b0;
            mem_req_addr       <= '0;
            mem_req_wdata      <= '0;
            rd_q               <= '0;
            regwrite_q         <= 1'b0;
            memory_data_memory <= '0;
            load_done          <= 1'b0;
            load_we            <= 1'b0;
            rd_load            <= '0;
        end else begin
            load_done <= 1'b0;
            load_we   <= 1'b0;
            if (accept) begin
                // A load wins when both read and write are flagged.
                mem_req_write <= !memRead_memory;
                mem_req_addr  <= addr_memory;
                mem_req_wdata <= wdata_memory;
                rd_q          <= rd_memory;
                regwrite_q    <= regWrite_memory;
            end
            if (rsp_take && !mem_req_write) begin
                memory_data_memory <= mem_rsp_data;
                load_done          <= 1'b1;
                load_we            <= regwrite_q && (rd_q != 5'd0);
                rd_load            <= rd_q;
            end
            if (timeout_fire) begin
                memory_data_memory <= '0;
                if (!mem_req_write) begin
                    load_done <= 1'b1;
                    rd_load   <= rd_q;
                end
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Saturates once the limit is reached so it can never wrap while waiting.
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt   <= '0;
            mem_error <= 1'b0;
        end else begin
            if (accept) begin
                tmo_cnt <= '0;
            end else if ((state == ST_REQ || state == ST_WAIT) && !timeout_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (timeout_fire) begin
                mem_error <= 1'b1;
            end
        end
    end

    assign timeout_hit = (tmo_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign mem_error          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule
